// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU stage: op encodings, FSM states and
// the multiplier iteration count.
package alu_pkg;

    localparam int unsigned MUL_ITERS = 32;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_NOR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/mul_shift_add_32.sv
// Iterative unsigned 32x32 shift-add multiplier datapath; one iteration per step.
module mul_shift_add_32 #(
    parameter int unsigned MUL_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [63:0] prod_next,
    output logic        last
);
    import alu_pkg::*;

    logic [31:0] mcand_q, mcand_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] sum;

    // acc_lo doubles as the multiplier shift register; the carry enters acc_hi's MSB.
    always_comb begin
        sum       = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : 33'd0);
        prod_next = {sum, acc_lo_q[31:1]};
        last      = (cnt_q == 6'(MUL_ITERS - 1));
    end

    always_comb begin
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = multiplicand;
            acc_hi_d = '0;
            acc_lo_d = multiplier;
            cnt_d    = '0;
        end else if (step) begin
            acc_hi_d = prod_next[63:32];
            acc_lo_d = prod_next[31:0];
            cnt_d    = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/my_or_32bit.sv
// Combinational 32-bit bitwise OR lane shared by the ALU stages.
module my_or_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = a | b;

endmodule

// File: rtl/alu_seq_32bit.sv
// Registered 32-bit ALU stage: single-cycle logic/arith lanes plus an iterative
// shift-add multiplier, with a one-cycle done strobe.
module alu_seq_32bit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MUL_ITERS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow
);
    import alu_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] or_y, add_y, sub_y, lane_res;
    logic             lane_ov, slt;
    logic             mul_load, mul_step, mul_last;
    logic [63:0]      prod_next;

    my_or_32bit u_or (
        .a (a),
        .b (b),
        .y (or_y)
    );

    mul_shift_add_32 #(.MUL_ITERS(MUL_ITERS)) u_mul (
        .clk          (clk),
        .reset        (reset),
        .load         (mul_load),
        .step         (mul_step),
        .multiplicand (a),
        .multiplier   (b),
        .prod_next    (prod_next),
        .last         (mul_last)
    );

    // SLT uses a true signed compare so it stays correct when a-b overflows.
    always_comb begin
        add_y    = a + b;
        sub_y    = a - b;
        slt      = ($signed(a) < $signed(b));
        lane_res = '0;
        lane_ov  = 1'b0;
        case (alu_op)
            OP_AND: lane_res = a & b;
            OP_OR:  lane_res = or_y;
            OP_ADD: begin
                lane_res = add_y;
                lane_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (add_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                lane_res = sub_y;
                lane_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: lane_res = a ^ b;
            OP_SLT: lane_res = WIDTH'(slt);
            OP_NOR: lane_res = ~(a | b);
            default: lane_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        mul_load    = 1'b0;
        mul_step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (alu_op == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = MUL_RUN;
                    end else begin
                        result_d    = lane_res;
                        result_hi_d = '0;
                        zero_d      = (lane_res == '0);
                        overflow_d  = lane_ov;
                        state_d     = DONE;
                    end
                end
            end
            MUL_RUN: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d    = prod_next[31:0];
                    result_hi_d = prod_next[63:32];
                    zero_d      = (prod_next[31:0] == '0);
                    overflow_d  = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq_32bit.sv
// Directed self-checking bench for alu_seq_32bit with hand-computed expectations.
module tb_alu_seq_32bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  alu_op;
    logic [31:0] a, b;
    logic        busy, done, zero, overflow;
    logic [31:0] result, result_hi;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_32bit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Start at edge T, then check the DONE cycle and the return to IDLE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_ov);
        @(negedge clk);
        start = 1'b1; alu_op = op; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".busy"}, 64'(busy), 64'd1);
        check({tag, ".result"}, 64'(result), 64'(exp_res));
        check({tag, ".result_hi"}, 64'(result_hi), 64'd0);
        check({tag, ".zero"}, 64'(zero), 64'(exp_zero));
        check({tag, ".overflow"}, 64'(overflow), 64'(exp_ov));
        @(posedge clk); #1;
        check({tag, ".done_drop"}, 64'(done), 64'd0);
        check({tag, ".idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; alu_op = 3'b001; a = 32'hFFFF_FFFF; b = 32'h1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("reset.busy", 64'(busy), 64'd0);
            check("reset.done", 64'(done), 64'd0);
        end
        check("reset.result", 64'(result), 64'd0);
        check("reset.result_hi", 64'(result_hi), 64'd0);
        check("reset.zero", 64'(zero), 64'd0);
        check("reset.overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;

        run_op("or",      3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
        run_op("add_ov",  3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        run_op("add",     3'b010, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_000F, 1'b0, 1'b0);
        run_op("sub_zero",3'b011, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
        run_op("sub_ov",  3'b011, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("slt_neg", 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        run_op("slt_ovf", 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("slt_no",  3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op("and",     3'b000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0);
        run_op("xor",     3'b100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0);
        run_op("nor",     3'b110, 32'hFFFF_0000, 32'h0000_FFFE, 32'h0000_0001, 1'b0, 1'b0);

        // start held through the DONE cycle must not launch a second op
        @(negedge clk);
        start = 1'b1; alu_op = 3'b000; a = 32'h0000_00F0; b = 32'h0000_00FF;
        @(posedge clk); #1;
        check("and2.done", 64'(done), 64'd1);
        check("and2.result", 64'(result), 64'h0000_00F0);
        alu_op = 3'b001; a = 32'h1234_0000; b = 32'h0000_5678;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_start.done", 64'(done), 64'd0);
        check("done_start.busy", 64'(busy), 64'd0);
        check("done_start.result", 64'(result), 64'h0000_00F0);

        // MUL 0xFFFFFFFF^2 with an ignored start at T+10
        @(negedge clk);
        start = 1'b1; alu_op = 3'b111; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        check("mul.busy_T1", 64'(busy), 64'd1);
        check("mul.done_T1", 64'(done), 64'd0);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            check("mul.run_busy", 64'(busy), 64'd1);
            check("mul.run_done", 64'(done), 64'd0);
            check("mul.run_hold", 64'(result), 64'h0000_00F0);
            if (k == 9) begin
                start = 1'b1; alu_op = 3'b001; a = 32'h0000_0001; b = 32'h0000_0002;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("mul.done", 64'(done), 64'd1);
        check("mul.busy_T33", 64'(busy), 64'd1);
        check("mul.result", 64'(result), 64'h0000_0001);
        check("mul.result_hi", 64'(result_hi), 64'hFFFF_FFFE);
        check("mul.zero", 64'(zero), 64'd0);
        check("mul.overflow", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        check("mul.done_drop", 64'(done), 64'd0);
        check("mul.idle", 64'(busy), 64'd0);
        check("mul.hold", 64'(result_hi), 64'hFFFF_FFFE);

        // MUL 3*7 completes normally
        @(negedge clk);
        start = 1'b1; alu_op = 3'b111; a = 32'd3; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 31; k++) @(posedge clk);
        #1;
        check("mul37.done_early", 64'(done), 64'd0);
        @(posedge clk); #1;
        check("mul37.done", 64'(done), 64'd1);
        check("mul37.result", 64'(result), 64'd21);
        check("mul37.result_hi", 64'(result_hi), 64'd0);

        // MUL with reset at T+15 aborts, then OR at T+17 completes at T+18
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b1; alu_op = 3'b111; a = 32'd3; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 14; k++) @(posedge clk);
        #1;
        check("abort.busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.result", 64'(result), 64'd0);
        check("abort.result_hi", 64'(result_hi), 64'd0);
        @(posedge clk); #1;
        check("abort.no_done", 64'(done), 64'd0);
        start = 1'b1; alu_op = 3'b001; a = 32'hF0F0_0000; b = 32'h0000_0F0F;
        @(posedge clk); #1;
        start = 1'b0;
        check("post_abort.done", 64'(done), 64'd1);
        check("post_abort.result", 64'(result), 64'hF0F0_0F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_32bit.md
Name: alu_seq_32bit

Overview:
Registered 32-bit ALU stage that consumes the team's combinational bitwise lanes (my_or_32bit and its siblings) and adds an iterative shift-add multiplier.
- Accepts one operation per start pulse and returns a registered result with a one-cycle done strobe.
- Sits between the register-file read stage and the writeback register; writeback samples result on done.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- MUL_ITERS, 32, shift-add iterations for MUL; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- alu_op  input  3  operation select, sampled with start
- a  input  32  operand A, sampled with start
- b  input  32  operand B, sampled with start
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle strobe; result valid
- result  output  32  low word / ALU result; held until next accepted start
- result_hi  output  32  high word of MUL product; 0 for other ops
- zero  output  1  (result == 0), registered with result
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise

Behaviour:
- Reset is synchronous, active-high, and applies at the next rising clk edge. All outputs and internal state clear: state=IDLE, busy=0, done=0, result=0, result_hi=0, zero=0, overflow=0, counter=0.
- Op encoding: 000 AND, 001 OR (via my_or_32bit instance), 010 ADD, 011 SUB, 100 XOR, 101 SLT (signed, result 1 or 0), 110 NOR, 111 MUL (unsigned 32x32 -> 64).
- State machine: IDLE, MUL_RUN, DONE.
- IDLE + start + op != MUL: result, zero and overflow are registered from the combinational lanes at the same edge; next state is DONE.
  - Start sampled at edge T gives done=1 during cycle T+1.
- IDLE + start + op == MUL: capture multiplicand=a, multiplier=b; clear the 64-bit accumulator and counter; next state is MUL_RUN.
- MUL_RUN, each cycle:
  - if multiplier[0], acc_hi += multiplicand (33-bit add, carry kept);
  - then shift {carry, acc_hi, acc_lo/multiplier} right by 1;
  - counter++.
  - After MUL_ITERS iterations, load result=acc[31:0] and result_hi=acc[63:32], set zero=(acc[31:0]==0), overflow=0, and go to DONE.
  - Done asserts at cycle T+33.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- start outside IDLE is ignored, with no queueing; this includes start during the DONE cycle.
- ADD/SUB arithmetic: 32-bit wraparound. overflow = (sign a == sign b') && (sign result != sign a), where b' = ~b for SUB.
- SLT: signed compare computed correctly even when a-b overflows; result_hi=0.
- result and result_hi hold their values between operations and change only at a completing edge.
- Reset asserted mid-MUL aborts the operation: no done, and outputs clear per the reset list.
- Unknown ops: none; all 8 encodings are defined.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings OP_AND..OP_MUL;
  - state enum {IDLE, MUL_RUN, DONE};
  - MUL_ITERS constant.
- Sub-module mul_shift_add_32: iterative datapath with accumulator, counter and load/step/finish controls. The alu_seq_32bit FSM drives it.
- Logic lanes reuse the existing 32-bit gate modules (e.g. my_or_32bit for OP_OR).

Test Plan:
- Reset held 2 cycles -> all outputs 0, busy=0; start during reset is ignored.
- OR a=0xF0F0_0000, b=0x0000_0F0F, start at T -> done at T+1, result=0xF0F0_0F0F, zero=0.
- ADD a=0x7FFF_FFFF, b=1 -> result=0x8000_0000, overflow=1. SUB a=5, b=5 -> result=0, zero=1.
- SLT a=0xFFFF_FFFF, b=1 -> result=1. SLT a=0x8000_0000, b=0x7FFF_FFFF -> result=1.
- MUL a=0xFFFF_FFFF, b=0xFFFF_FFFF -> done at T+33, result=0x0000_0001, result_hi=0xFFFF_FFFE.
  - busy=1 from T+1 through T+33.
  - A start at T+10 is ignored.
- MUL a=3, b=7 with reset at T+15 -> no done; outputs 0 next cycle. A following OR start at T+17 completes normally at T+18.
